// File: rtl/cmp_row_assembler_if.sv
// Sample stream in, packed comparator rows out, for cmp_row_assembler.
// The master side drives the sample stream; the slave side is the assembler.
interface cmp_row_assembler_if #(
  parameter int NUM_OF_COLUMNS = 2,
  parameter int SAMPLE_WIDTH   = 32
);
  logic [SAMPLE_WIDTH-1:0] sample_in;
  logic                    sample_valid;
  logic                    flush;
  logic [31:0]             data_to_cmp [NUM_OF_COLUMNS];
  logic                    enable_out;
  logic [31:0]             row_count;
  logic                    done;

  modport master (
    output sample_in, sample_valid, flush,
    input  data_to_cmp, enable_out, row_count, done
  );

  modport slave (
    input  sample_in, sample_valid, flush,
    output data_to_cmp, enable_out, row_count, done
  );
endinterface

// File: rtl/cmp_row_assembler.sv
// Packs a serial sample stream into NUM_OF_COLUMNS-wide integer rows for the
// comparator, with start-up skipping, padded flush and an optional row budget.
module cmp_row_assembler #(
  parameter int NUM_OF_COLUMNS  = 2,
  parameter int SAMPLE_WIDTH    = 32,
  parameter int SIGNED          = 1,
  parameter int SAMPLES_TO_SKIP = 0,
  parameter int PAD_VALUE       = 0,
  parameter int MAX_ROWS        = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  cmp_row_assembler_if.slave bus
);
  localparam int CW = (NUM_OF_COLUMNS > 1) ? $clog2(NUM_OF_COLUMNS) : 1;

  typedef enum logic [1:0] {SKIP, FILL, DONE} state_t;
  localparam state_t RESET_STATE = (SAMPLES_TO_SKIP > 0) ? SKIP : FILL;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [31:0]   skip_q, skip_d;
  logic [31:0]   staging_q [NUM_OF_COLUMNS];
  logic [31:0]   staging_d [NUM_OF_COLUMNS];
  logic [31:0]   data_q    [NUM_OF_COLUMNS];
  logic [31:0]   data_d    [NUM_OF_COLUMNS];
  logic          en_q, en_d;
  logic [31:0]   cnt_q, cnt_d;
  logic          done_q, done_d;

  logic [31:0]   ext_sample;
  logic [CW:0]   fill;
  logic          row_full;
  logic          emit;

  if (SAMPLE_WIDTH == 32) begin : g_pass
    assign ext_sample = bus.sample_in;
  end else begin : g_ext
    assign ext_sample = {{(32-SAMPLE_WIDTH){(SIGNED != 0) && bus.sample_in[SAMPLE_WIDTH-1]}},
                         bus.sample_in};
  end

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    skip_d    = skip_q;
    staging_d = staging_q;
    data_d    = data_q;
    en_d      = 1'b0;
    cnt_d     = cnt_q;
    done_d    = done_q;
    fill      = '0;
    row_full  = 1'b0;
    emit      = 1'b0;
    case (state_q)
      SKIP: begin
        if (bus.sample_valid) begin
          skip_d = skip_q + 32'd1;
          if (skip_q == 32'(SAMPLES_TO_SKIP - 1)) state_d = FILL;
        end
      end
      FILL: begin
        // The incoming sample is staged before deciding to emit, so a flush in the
        // same cycle sees it and a completing sample never produces a second row.
        fill = {1'b0, col_q};
        if (bus.sample_valid) begin
          staging_d[col_q] = ext_sample;
          fill = fill + 1'b1;
        end
        row_full = bus.sample_valid && (col_q == CW'(NUM_OF_COLUMNS - 1));
        emit     = row_full || (bus.flush && (fill != '0));
        if (bus.sample_valid && !row_full) col_d = col_q + 1'b1;
        if (emit) begin
          for (int unsigned i = 0; i < NUM_OF_COLUMNS; i++) begin
            data_d[i] = ((CW+1)'(i) < fill) ? staging_d[i] : 32'(PAD_VALUE);
          end
          col_d = '0;
          en_d  = 1'b1;
          cnt_d = cnt_q + 32'd1;
          if (MAX_ROWS != 0 && cnt_d == 32'(MAX_ROWS)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RESET_STATE;
      col_q     <= '0;
      skip_q    <= '0;
      staging_q <= '{default: '0};
      data_q    <= '{default: '0};
      en_q      <= 1'b0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      skip_q    <= skip_d;
      staging_q <= staging_d;
      data_q    <= data_d;
      en_q      <= en_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
    end
  end

  assign bus.data_to_cmp = data_q;
  assign bus.enable_out  = en_q;
  assign bus.row_count   = cnt_q;
  assign bus.done        = done_q;
endmodule

// File: tb/tb_cmp_row_assembler.sv
// Four assembler configurations checked every cycle against a queue-based row
// model, plus literal expectations for the hand-worked scenarios.
module tb_cmp_row_assembler;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  bit   run = 1'b0;
  always #5 clk = ~clk;

  // Instance configs: 0=A, 1=B, 2=C, 3=D
  localparam int M_NC[4]   = '{3, 2, 4, 1};
  localparam int M_SW[4]   = '{32, 32, 8, 8};
  localparam int M_SG[4]   = '{1, 1, 1, 0};
  localparam int M_SKIP[4] = '{0, 2, 0, 0};
  localparam int M_PAD[4]  = '{0, 0, -1, 0};
  localparam int M_MAX[4]  = '{0, 0, 0, 2};

  logic        in_v [4];
  logic        in_f [4];
  logic [31:0] in_s [4];

  int n_tests = 0;
  int n_fail  = 0;

  cmp_row_assembler_if #(.NUM_OF_COLUMNS(3), .SAMPLE_WIDTH(32)) if_a ();
  cmp_row_assembler_if #(.NUM_OF_COLUMNS(2), .SAMPLE_WIDTH(32)) if_b ();
  cmp_row_assembler_if #(.NUM_OF_COLUMNS(4), .SAMPLE_WIDTH(8))  if_c ();
  cmp_row_assembler_if #(.NUM_OF_COLUMNS(1), .SAMPLE_WIDTH(8))  if_d ();

  assign if_a.sample_in = in_s[0];       assign if_a.sample_valid = in_v[0]; assign if_a.flush = in_f[0];
  assign if_b.sample_in = in_s[1];       assign if_b.sample_valid = in_v[1]; assign if_b.flush = in_f[1];
  assign if_c.sample_in = in_s[2][7:0];  assign if_c.sample_valid = in_v[2]; assign if_c.flush = in_f[2];
  assign if_d.sample_in = in_s[3][7:0];  assign if_d.sample_valid = in_v[3]; assign if_d.flush = in_f[3];

  cmp_row_assembler #(.NUM_OF_COLUMNS(3), .SAMPLE_WIDTH(32), .SIGNED(1), .SAMPLES_TO_SKIP(0),
                      .PAD_VALUE(0), .MAX_ROWS(0))
    dut_a (.clk(clk), .reset_n(reset_n), .bus(if_a.slave));
  cmp_row_assembler #(.NUM_OF_COLUMNS(2), .SAMPLE_WIDTH(32), .SIGNED(1), .SAMPLES_TO_SKIP(2),
                      .PAD_VALUE(0), .MAX_ROWS(0))
    dut_b (.clk(clk), .reset_n(reset_n), .bus(if_b.slave));
  cmp_row_assembler #(.NUM_OF_COLUMNS(4), .SAMPLE_WIDTH(8), .SIGNED(1), .SAMPLES_TO_SKIP(0),
                      .PAD_VALUE(-1), .MAX_ROWS(0))
    dut_c (.clk(clk), .reset_n(reset_n), .bus(if_c.slave));
  cmp_row_assembler #(.NUM_OF_COLUMNS(1), .SAMPLE_WIDTH(8), .SIGNED(0), .SAMPLES_TO_SKIP(0),
                      .PAD_VALUE(0), .MAX_ROWS(2))
    dut_d (.clk(clk), .reset_n(reset_n), .bus(if_d.slave));

  // Behavioural model: a queue of pending samples per instance
  int          part [4][$];
  int          skip_cnt [4];
  bit          e_en [4];
  int          e_row [4][64];
  int unsigned e_cnt [4];
  bit          e_done [4];

  function automatic int ext(int k, logic [31:0] s);
    longint v;
    longint m;
    m = (64'sd1 <<< M_SW[k]) - 1;
    v = longint'(s) & m;
    if (M_SG[k] != 0 && M_SW[k] < 32 && v >= (64'sd1 <<< (M_SW[k] - 1)))
      v = v - (64'sd1 <<< M_SW[k]);
    return int'(v);
  endfunction

  task automatic mdl_reset();
    for (int k = 0; k < 4; k++) begin
      part[k].delete();
      skip_cnt[k] = 0;
      e_en[k]     = 1'b0;
      e_cnt[k]    = 0;
      e_done[k]   = 1'b0;
      for (int i = 0; i < 64; i++) e_row[k][i] = 0;
    end
  endtask

  task automatic mdl_step();
    for (int k = 0; k < 4; k++) begin
      e_en[k] = 1'b0;
      if (e_done[k]) continue;
      if (skip_cnt[k] < M_SKIP[k]) begin
        if (in_v[k]) skip_cnt[k]++;
        continue;
      end
      if (in_v[k]) part[k].push_back(ext(k, in_s[k]));
      if (part[k].size() == M_NC[k] || (in_f[k] && part[k].size() > 0)) begin
        for (int i = 0; i < M_NC[k]; i++)
          e_row[k][i] = (i < part[k].size()) ? part[k][i] : M_PAD[k];
        part[k].delete();
        e_en[k] = 1'b1;
        e_cnt[k]++;
        if (M_MAX[k] != 0 && e_cnt[k] == M_MAX[k]) e_done[k] = 1'b1;
      end
    end
  endtask

  initial begin
    mdl_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) mdl_reset();
      else mdl_step();
    end
  end

  task automatic chk(string name, int act, int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Per-cycle comparison of every instance against the model
  int          d_row [4][64];
  logic        d_en [4];
  logic [31:0] d_cnt [4];
  logic        d_done [4];

  task automatic compare_all();
    for (int i = 0; i < 3; i++) d_row[0][i] = int'(if_a.data_to_cmp[i]);
    for (int i = 0; i < 2; i++) d_row[1][i] = int'(if_b.data_to_cmp[i]);
    for (int i = 0; i < 4; i++) d_row[2][i] = int'(if_c.data_to_cmp[i]);
    d_row[3][0] = int'(if_d.data_to_cmp[0]);
    d_en[0] = if_a.enable_out; d_cnt[0] = if_a.row_count; d_done[0] = if_a.done;
    d_en[1] = if_b.enable_out; d_cnt[1] = if_b.row_count; d_done[1] = if_b.done;
    d_en[2] = if_c.enable_out; d_cnt[2] = if_c.row_count; d_done[2] = if_c.done;
    d_en[3] = if_d.enable_out; d_cnt[3] = if_d.row_count; d_done[3] = if_d.done;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("m%0d.enable_out", k), int'(d_en[k]), int'(e_en[k]));
      chk($sformatf("m%0d.row_count", k), int'(d_cnt[k]), int'(e_cnt[k]));
      chk($sformatf("m%0d.done", k), int'(d_done[k]), int'(e_done[k]));
      for (int i = 0; i < M_NC[k]; i++)
        chk($sformatf("m%0d.data[%0d]", k, i), d_row[k][i], e_row[k][i]);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (run) compare_all();
    end
  end

  // Drive one cycle on instance k starting at a falling edge; returns at the next
  // falling edge, when the outputs reflect the sampled inputs.
  task automatic step(int k, logic v, logic [31:0] s, logic f);
    in_v[k] = v;
    in_s[k] = s;
    in_f[k] = f;
    @(negedge clk);
    in_v[k] = 1'b0;
    in_f[k] = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      in_v[k] = 1'b0; in_f[k] = 1'b0; in_s[k] = '0;
    end
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    run = 1'b1;
    chk("rst.a.en", int'(if_a.enable_out), 0);
    chk("rst.a.cnt", int'(if_a.row_count), 0);
    chk("rst.d.done", int'(if_d.done), 0);

    // A: 1..6 on consecutive cycles, NC=3
    step(0, 1, 1, 0); step(0, 1, 2, 0);
    chk("a.no_pulse_early", int'(if_a.enable_out), 0);
    step(0, 1, 3, 0);
    chk("a.row1.en", int'(if_a.enable_out), 1);
    chk("a.row1.c0", int'(if_a.data_to_cmp[0]), 1);
    chk("a.row1.c2", int'(if_a.data_to_cmp[2]), 3);
    step(0, 1, 4, 0); step(0, 1, 5, 0); step(0, 1, 6, 0);
    chk("a.row2.c0", int'(if_a.data_to_cmp[0]), 4);
    chk("a.row2.c1", int'(if_a.data_to_cmp[1]), 5);
    chk("a.row2.c2", int'(if_a.data_to_cmp[2]), 6);
    chk("a.row_count", int'(if_a.row_count), 2);
    step(0, 0, 0, 0);
    chk("a.hold.en", int'(if_a.enable_out), 0);
    chk("a.hold.c2", int'(if_a.data_to_cmp[2]), 6);
    step(0, 1, 7, 0); step(0, 1, 8, 1);
    chk("a.flushsample.c1", int'(if_a.data_to_cmp[1]), 8);
    chk("a.flushsample.pad", int'(if_a.data_to_cmp[2]), 0);

    // B: skip two, with idle gaps
    step(1, 1, 9, 0); step(1, 0, 0, 0); step(1, 1, 9, 1); step(1, 0, 0, 0);
    step(1, 1, 7, 0); step(1, 0, 0, 0);
    chk("b.skip.no_pulse", int'(if_b.row_count), 0);
    step(1, 1, 8, 0);
    chk("b.row.c0", int'(if_b.data_to_cmp[0]), 7);
    chk("b.row.c1", int'(if_b.data_to_cmp[1]), 8);
    step(1, 1, 7, 0); step(1, 1, 8, 1);
    chk("b.flushfull.en", int'(if_b.enable_out), 1);
    step(1, 0, 0, 1);
    chk("b.flushfull.single", int'(if_b.enable_out), 0);
    chk("b.flushfull.cnt", int'(if_b.row_count), 2);

    // C: pad and signed 8-bit extension
    step(2, 1, 5, 0); step(2, 1, 6, 0); step(2, 0, 0, 1);
    chk("c.pad.c1", int'(if_c.data_to_cmp[1]), 6);
    chk("c.pad.c3", int'(if_c.data_to_cmp[3]), -1);
    step(2, 1, 32'hF0, 1);
    chk("c.signed.c0", int'(if_c.data_to_cmp[0]), -16);

    // D: unsigned extension and row budget
    step(3, 1, 32'hF0, 0);
    chk("d.unsigned.c0", int'(if_d.data_to_cmp[0]), 240);
    chk("d.done.early", int'(if_d.done), 0);
    step(3, 1, 1, 0);
    chk("d.done.with_last", int'(if_d.done), 1);
    chk("d.en.with_last", int'(if_d.enable_out), 1);
    step(3, 1, 2, 0); step(3, 1, 3, 1); step(3, 1, 4, 0);
    chk("d.frozen.cnt", int'(if_d.row_count), 2);
    chk("d.frozen.en", int'(if_d.enable_out), 0);

    // Reset mid-row on B, then skip again and build {3,4}
    step(1, 1, 50, 0);
    #2 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    chk("rst2.b.cnt", int'(if_b.row_count), 0);
    chk("rst2.b.c0", int'(if_b.data_to_cmp[0]), 0);
    @(negedge clk);
    step(1, 1, 1, 0); step(1, 1, 2, 0); step(1, 1, 3, 0); step(1, 1, 4, 0);
    chk("rst2.b.row.c0", int'(if_b.data_to_cmp[0]), 3);
    chk("rst2.b.row.c1", int'(if_b.data_to_cmp[1]), 4);
    chk("rst2.b.cnt1", int'(if_b.row_count), 1);
    step(1, 0, 0, 0);

    run = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
